// File: rtl/gpr_writeback.sv
// gpr_writeback: register-file write-port arbiter merging pipeline writeback with a
// long-latency result FIFO, plus a pending scoreboard for decode operand stalls.
module gpr_writeback #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_rd,
    input  logic [DW-1:0] pipe_rrd,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic          ll_valid,
    output logic          ll_ready,
    input  logic [AW-1:0] ll_rd,
    input  logic [DW-1:0] ll_data,
    input  logic [AW-1:0] chk_rs,
    input  logic [AW-1:0] chk_rt,
    output logic          busy_rs,
    output logic          busy_rt,
    output logic          gpr_we,
    output logic [AW-1:0] gpr_rd,
    output logic [DW-1:0] gpr_rrd,
    output logic [PW:0]   ll_count
);
    logic [AW-1:0]      rd_mem [DEPTH];
    logic [DW-1:0]      data_mem [DEPTH];
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [PW:0]        count_q, count_d;
    logic [2**AW-1:0]   pending_q, pending_d;
    logic               push, drain;
    logic [AW-1:0]      head_rd;

    assign head_rd  = rd_mem[rptr_q];
    assign ll_ready = rst && (count_q != DEPTH[PW:0]);
    // $0 results complete the handshake but never occupy a slot
    assign push     = ll_valid && ll_ready && (ll_rd != '0);
    assign drain    = rst && !pipe_we && (count_q != '0);
    assign gpr_rd   = pipe_we ? pipe_rd : head_rd;
    assign gpr_rrd  = pipe_we ? pipe_rrd : data_mem[rptr_q];
    assign gpr_we   = rst && (pipe_we || drain) && (gpr_rd != '0);
    assign ll_count = count_q;
    assign count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, drain};
    // the register file forwards same-cycle writes, so the draining register is not busy
    assign busy_rs  = rst && pending_q[chk_rs] && !(drain && head_rd == chk_rs);
    assign busy_rt  = rst && pending_q[chk_rt] && !(drain && head_rd == chk_rt);

    always_comb begin
        pending_d = pending_q;
        if (drain) pending_d[head_rd] = 1'b0;
        if (issue_valid && issue_rd != '0) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            wptr_q    <= wptr_q + {{(PW-1){1'b0}}, push};
            rptr_q    <= rptr_q + {{(PW-1){1'b0}}, drain};
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr_q]   <= ll_rd;
            data_mem[wptr_q] <= ll_data;
        end
    end
endmodule
